// File: rtl/alu_pipe_unit.sv
// ----------------------------------------------------------------------------
// alu_pipe_unit
// Handshaked ALU for the EX stage of the pipelined CPU. Single-cycle ops
// (pass/add/sub/and/or/xor) land in the output register one edge after
// accept. Multiply (cntrl=111, MUL_EN=1) runs an iterative shift-add, one
// multiplier bit per cycle, and presents the low WIDTH bits of the product.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   command/operands valid
//   in_ready   unit can accept a command this cycle (does not look at in_valid)
//   cntrl      000/001 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor, 111 mul
//   A, B       WIDTH-bit operands
//   out_valid  result and flags valid
//   out_ready  consumer takes the result this cycle
//   result     registered result
//   negative   result MSB
//   zero       result == 0
//   overflow   signed overflow (add/sub only)
//   carry_out  carry out of the MSB (add/sub only; sub: 1 = no borrow)
// ----------------------------------------------------------------------------
module alu_pipe_unit #(
    parameter int WIDTH  = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       cntrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_r, state_next_s;

    logic [WIDTH-1:0] result_r;
    logic             out_valid_r, negative_r, zero_r, overflow_r, carry_r;

    logic [WIDTH-1:0] mcand_r, mplier_r, acc_r, acc_step_s;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH:0]   add_full_s, sub_full_s;
    logic [WIDTH-1:0] alu_result_s;
    logic             alu_v_s, alu_c_s;

    logic             out_free_s, accept_s, is_mul_s;
    logic             wr_en_s, wr_v_s, wr_c_s, mul_start_s, mul_step_s;
    logic [WIDTH-1:0] wr_result_s;

    // The output register can take a new value if it is empty or being drained now.
    assign out_free_s = !out_valid_r || out_ready;
    assign in_ready   = (state_r == ST_IDLE) && out_free_s;
    assign accept_s   = in_valid && in_ready;
    assign is_mul_s   = MUL_EN && (cntrl == 3'b111);

    assign out_valid  = out_valid_r;
    assign result     = result_r;
    assign negative   = negative_r;
    assign zero       = zero_r;
    assign overflow   = overflow_r;
    assign carry_out  = carry_r;

    // Subtraction is A + ~B + 1 so the carry reads as "no borrow".
    assign add_full_s = {1'b0, A} + {1'b0, B};
    assign sub_full_s = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
    assign acc_step_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

    // Single-cycle ALU datapath; cntrl=111 yields zero here (multiply goes through the FSM).
    always_comb begin
        alu_result_s = {WIDTH{1'b0}};
        alu_v_s      = 1'b0;
        alu_c_s      = 1'b0;
        case (cntrl)
            3'b000, 3'b001: alu_result_s = B;
            3'b010: begin
                alu_result_s = add_full_s[MSB:0];
                alu_c_s      = add_full_s[WIDTH];
                alu_v_s      = (A[MSB] == B[MSB]) && (add_full_s[MSB] != A[MSB]);
            end
            3'b011: begin
                alu_result_s = sub_full_s[MSB:0];
                alu_c_s      = sub_full_s[WIDTH];
                alu_v_s      = (A[MSB] == ~B[MSB]) && (sub_full_s[MSB] != A[MSB]);
            end
            3'b100:  alu_result_s = A & B;
            3'b101:  alu_result_s = A | B;
            3'b110:  alu_result_s = A ^ B;
            default: alu_result_s = {WIDTH{1'b0}};
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and control: decides when the output register is written.
    always_comb begin
        state_next_s = state_r;
        wr_en_s      = 1'b0;
        wr_result_s  = {WIDTH{1'b0}};
        wr_v_s       = 1'b0;
        wr_c_s       = 1'b0;
        mul_start_s  = 1'b0;
        mul_step_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mul_s) begin
                    mul_start_s  = 1'b1;
                    state_next_s = ST_MUL;
                end else if (accept_s) begin
                    wr_en_s     = 1'b1;
                    wr_result_s = alu_result_s;
                    wr_v_s      = alu_v_s;
                    wr_c_s      = alu_c_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                mul_step_s = 1'b1;
                // The final step's sum is forwarded straight into the output register.
                if ((cnt_r == CNT_LAST) && out_free_s) begin
                    wr_en_s      = 1'b1;
                    wr_result_s  = acc_step_s;
                    state_next_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            ST_HOLD: begin
                if (out_free_s) begin
                    wr_en_s      = 1'b1;
                    wr_result_s  = acc_r;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output register: result, flags and out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r    <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            negative_r  <= 1'b0;
            zero_r      <= 1'b0;
            overflow_r  <= 1'b0;
            carry_r     <= 1'b0;
        end else if (wr_en_s) begin
            result_r    <= wr_result_s;
            out_valid_r <= 1'b1;
            negative_r  <= wr_result_s[MSB];
            zero_r      <= (wr_result_s == {WIDTH{1'b0}});
            overflow_r  <= wr_v_s;
            carry_r     <= wr_c_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Multiply datapath: operand latch on accept, one shift-add step per MUL cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (mul_start_s) begin
            mcand_r  <= A;
            mplier_r <= B;
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (mul_step_s) begin
            mcand_r  <= {mcand_r[MSB-1:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[MSB:1]};
            acc_r    <= acc_step_s;
            cnt_r    <= cnt_r + CNT_ONE;
        end else begin
            acc_r    <= acc_r;
        end
    end

endmodule
